// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder_pkg: shared digit width and controller state encoding
package digit_serial_adder_pkg;
  localparam int DIGIT_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if: start/busy/done handshake plus operand and result buses
interface digit_serial_adder_if #(parameter int WIDTH = 8);
  logic start, cin, busy, done, C_Out;
  logic [WIDTH-1:0] a, b, Sum;
  modport master(output start, a, b, cin, input busy, done, Sum, C_Out);
  modport slave(input start, a, b, cin, output busy, done, Sum, C_Out);
endinterface

// File: rtl/digit_serial_adder_rca.sv
// Ripple_Carry_Adder: 2-bit ripple-carry slice used once per digit cycle
module Ripple_Carry_Adder (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       cin,
  output logic [1:0] Sum,
  output logic       C_Out
);
  logic c1;
  always_comb begin
    Sum[0] = a[0] ^ b[0] ^ cin;
    c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    Sum[1] = a[1] ^ b[1] ^ c1;
    C_Out  = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
  end
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add computed two bits per clock through one slice
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  digit_serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = N > 1 ? $clog2(N) : 1;

  if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_width_chk
    $error("digit_serial_adder: WIDTH must be even and >= 2");
  end

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic [DIGIT_W-1:0] s_sum;
  logic carry, s_co, accept, last;

  Ripple_Carry_Adder RCA0 (
    .a(a_sh[DIGIT_W-1:0]),
    .b(b_sh[DIGIT_W-1:0]),
    .cin(carry),
    .Sum(s_sum),
    .C_Out(s_co)
  );

  // new digit enters at the top so the sum is aligned after the last digit
  always_comb begin
    accept   = bus.start && state != RUN;
    last     = cnt == CW'(N - 1);
    sum_nx   = (sum_sh >> DIGIT_W) | (WIDTH'(s_sum) << (WIDTH - DIGIT_W));
    state_nx = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
  end

  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      bus.Sum   <= '0;
      bus.C_Out <= 1'b0;
    end else if (accept) begin
      a_sh      <= bus.a;
      b_sh      <= bus.b;
      sum_sh    <= '0;
      carry     <= bus.cin;
      cnt       <= '0;
      bus.Sum   <= '0;
      bus.C_Out <= 1'b0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT_W;
      b_sh   <= b_sh >> DIGIT_W;
      sum_sh <= sum_nx;
      carry  <= s_co;
      cnt    <= cnt + CW'(1);
      if (last) begin
        bus.Sum   <= sum_nx;
        bus.C_Out <= s_co;
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed and exhaustive checks for WIDTH=8, 4 and 2
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_adder_if #(.WIDTH(8)) bus8 ();
  digit_serial_adder_if #(.WIDTH(4)) bus4 ();
  digit_serial_adder_if #(.WIDTH(2)) bus2 ();

  digit_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  digit_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  digit_serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.start = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.cin = c;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
    bus8.cin = 1'($urandom);
    check("accept_busy", 64'(bus8.busy), 64'd1);
  endtask

  task automatic wait8(input string tag, input int cyc, input logic [8:0] exp, input bit fall);
    int n = 0;
    while (!bus8.done && n < 20) begin
      check({tag, "_busy"}, 64'(bus8.busy), 64'd1);
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(cyc));
    check({tag, "_res"}, 64'({bus8.C_Out, bus8.Sum}), 64'(exp));
    check({tag, "_nobusy"}, 64'(bus8.busy), 64'd0);
    if (fall) begin
      @(negedge clk);
      check({tag, "_pulse"}, 64'({bus8.busy, bus8.done}), 64'd0);
      check({tag, "_hold"}, 64'({bus8.C_Out, bus8.Sum}), 64'(exp));
    end
  endtask

  initial begin
    int n;
    {bus8.start, bus8.a, bus8.b, bus8.cin} = '0;
    {bus4.start, bus4.a, bus4.b, bus4.cin} = '0;
    {bus2.start, bus2.a, bus2.b, bus2.cin} = '0;
    repeat (2) @(negedge clk);
    check("rst_out8", 64'({bus8.busy, bus8.done, bus8.C_Out, bus8.Sum}), 64'd0);
    check("rst_out2", 64'({bus2.busy, bus2.done, bus2.C_Out, bus2.Sum}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    go8(8'hFF, 8'h01, 1'b0);
    wait8("ff01", 4, 9'h100, 1);
    go8(8'h5A, 8'hA5, 1'b1);
    wait8("5aa5", 4, 9'h100, 1);
    go8(8'h3C, 8'h42, 1'b0);
    wait8("3c42", 4, 9'h07E, 1);

    go8(8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a = 8'h11;
    @(negedge clk);
    bus8.start = 1'b0;
    wait8("ignore", 2, 9'h100, 1);

    go8(8'hFF, 8'h01, 1'b0);
    wait8("b2b_first", 4, 9'h100, 0);
    go8(8'h0F, 8'h01, 1'b0);
    wait8("b2b_second", 4, 9'h010, 1);

    go8(8'h5A, 8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out", 64'({bus8.busy, bus8.done, bus8.C_Out, bus8.Sum}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(bus8.done);
    end
    check("midrst_nodone", 64'(n), 64'd0);
    go8(8'h3C, 8'h42, 1'b0);
    wait8("after_rst", 4, 9'h07E, 1);

    bus2.start = 1'b1;
    bus2.a = 2'b11;
    bus2.b = 2'b11;
    bus2.cin = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    bus2.a = 2'b00;
    bus2.b = 2'b00;
    bus2.cin = 1'b0;
    check("w2_busy", 64'(bus2.busy), 64'd1);
    @(negedge clk);
    check("w2_done", 64'(bus2.done), 64'd1);
    check("w2_res", 64'({bus2.C_Out, bus2.Sum}), 64'h7);
    @(negedge clk);
    check("w2_pulse", 64'(bus2.done), 64'd0);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          bus2.start = 1'b1;
          bus2.a = x[1:0];
          bus2.b = y[1:0];
          bus2.cin = c[0];
          @(negedge clk);
          bus2.start = 1'b0;
          n = 0;
          while (!bus2.done && n < 10) begin
            @(negedge clk);
            n++;
          end
          check("w2_sweep_lat", 64'(n), 64'd1);
          check("w2_sweep_res", 64'({bus2.C_Out, bus2.Sum}), 64'(x + y + c));
        end

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          bus4.start = 1'b1;
          bus4.a = x[3:0];
          bus4.b = y[3:0];
          bus4.cin = c[0];
          @(negedge clk);
          bus4.start = 1'b0;
          bus4.a = ~x[3:0];
          n = 0;
          while (!bus4.done && n < 10) begin
            @(negedge clk);
            n++;
          end
          check("w4_sweep_lat", 64'(n), 64'd2);
          check("w4_sweep_res", 64'({bus4.C_Out, bus4.Sum}), 64'(x + y + c));
        end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
